// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT    = 3'd2,
    READBACK = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/config_loader_crc16.sv
// Bit-serial CRC-16 (MSB-first feedback) used to fingerprint chain traffic.
module crc16_serial
  import config_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/config_loader.sv
// Serial configuration-chain writer fed by a valid/ready word stream.
// Optional chain readback with CRC compare is built when CONFIG_READBACK_EN is defined.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH = 1024,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_en,
  input  logic                  config_out,
  output logic                  busy,
  output logic                  done,
  output logic                  readback_err
);

  localparam int SENT_W = $clog2(CONFIG_WIDTH + 1);
  localparam int BIT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [SENT_W-1:0] LAST_BIT = SENT_W'(CONFIG_WIDTH - 1);
  localparam logic [BIT_W-1:0]  LAST_IDX = BIT_W'(WORD_WIDTH - 1);

  state_t                state;
  logic [WORD_WIDTH-1:0] word_reg;
  logic [SENT_W-1:0]     bits_sent;
  logic [BIT_W-1:0]      bit_idx;
  logic                  config_in_q;
  logic                  start_ok;

  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // word_reg holds the not-yet-emitted bits of the current word, LSB next.
  always_ff @(posedge clk) begin
    if (state == FETCH && word_valid && word_ready) begin
      word_reg <= word_data >> 1;
    end else if (state == SHIFT) begin
      word_reg <= word_reg >> 1;
    end
  end

`ifdef CONFIG_READBACK_EN
  logic        err_armed;
  logic [15:0] crc_load;
  logic [15:0] crc_rb;

  crc16_serial u_crc_load (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .en     (state == SHIFT),
    .bit_in (config_in_q),
    .crc    (crc_load)
  );

  crc16_serial u_crc_rb (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .en     (state == READBACK),
    .bit_in (config_out),
    .crc    (crc_rb)
  );

  // During readback the tail bit is fed straight back so the chain rotates in place.
  assign config_in    = (state == READBACK) ? config_out : config_in_q;
  assign readback_err = err_armed && (crc_load != crc_rb);
`else
  logic unused_config_out;
  assign unused_config_out = config_out;
  assign config_in         = config_in_q;
  assign readback_err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_ready  <= 1'b0;
      config_in_q <= 1'b0;
      config_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bits_sent   <= '0;
      bit_idx     <= '0;
`ifdef CONFIG_READBACK_EN
      err_armed   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state      <= FETCH;
            word_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            bits_sent  <= '0;
            bit_idx    <= '0;
`ifdef CONFIG_READBACK_EN
            err_armed  <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (word_valid && word_ready) begin
            state       <= SHIFT;
            word_ready  <= 1'b0;
            config_en   <= 1'b1;
            config_in_q <= word_data[0];
            bit_idx     <= '0;
          end
        end
        SHIFT: begin
          bits_sent <= bits_sent + 1'b1;
          if (bits_sent == LAST_BIT) begin
`ifdef CONFIG_READBACK_EN
            state     <= READBACK;
            bits_sent <= '0;
`else
            state     <= DONE;
            config_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
`endif
          end else if (bit_idx == LAST_IDX) begin
            state      <= FETCH;
            word_ready <= 1'b1;
            config_en  <= 1'b0;
          end else begin
            bit_idx     <= bit_idx + 1'b1;
            config_in_q <= word_reg[0];
          end
        end
`ifdef CONFIG_READBACK_EN
        READBACK: begin
          bits_sent <= bits_sent + 1'b1;
          if (bits_sent == LAST_BIT) begin
            state     <= DONE;
            config_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err_armed <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
